// File: rtl/cache_refill_ctrl_pkg.sv
// Shared definitions for the cache refill controller: FSM state encoding,
// block geometry and the word-order helper used for critical-word-first.
package cache_refill_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FILL  = 2'd2
    } refill_state_t;

    localparam int WORDS_PER_BLOCK = 4;
    localparam int OFFSET_BITS     = 2;

    // Word offset of the current beat when the fetch starts at the requested
    // word; the 2-bit add wraps naturally from 3 back to 0.
    function automatic logic [OFFSET_BITS-1:0] calc_word_sel(
        input logic [OFFSET_BITS-1:0] start_off,
        input logic [OFFSET_BITS-1:0] beat
    );
        return start_off + beat;
    endfunction

endpackage

// File: rtl/cache_refill_ctrl_refill_buffer.sv
// refill_buffer: four word slots filled one beat at a time, presented as a
// packed block with word k at bits [k*DATA_WIDTH +: DATA_WIDTH].
module refill_buffer
    import cache_refill_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 wr_en,
    input  logic [OFFSET_BITS-1:0]               wr_sel,
    input  logic [DATA_WIDTH-1:0]                wr_data,
    output logic [WORDS_PER_BLOCK*DATA_WIDTH-1:0] block_data
);

    logic [DATA_WIDTH-1:0] slots [WORDS_PER_BLOCK];

    // Store the incoming memory word into the slot matching its block offset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < WORDS_PER_BLOCK; k++) begin
                slots[k] <= '0;
            end
        end else if (wr_en) begin
            slots[wr_sel] <= wr_data;
        end
    end

    // Pack the slot registers into the block bus seen by the cache.
    always_comb begin
        block_data = '0;
        for (int k = 0; k < WORDS_PER_BLOCK; k++) begin
            block_data[k*DATA_WIDTH +: DATA_WIDTH] = slots[k];
        end
    end

endmodule

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: miss handler for the direct-mapped cache. On a read miss
// it fetches the 4-word block one word per memory handshake, then writes the
// whole block into the cache in a single write-enable cycle.
// Optional feature: define CRITICAL_WORD_FIRST_EN to start the fetch at the
// requested word and wrap; otherwise words are fetched in order 0..3.
module cache_refill_ctrl
    import cache_refill_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  cpu_rd_en,
    input  logic [ADDR_WIDTH-1:0]                 cpu_addr,
    input  logic                                  hit,
    output logic                                  stall,
    output logic                                  mem_req,
    output logic [ADDR_WIDTH-1:0]                 mem_addr,
    input  logic                                  mem_ready,
    input  logic [DATA_WIDTH-1:0]                 mem_rdata,
    output logic                                  cache_wr_en,
    output logic [ADDR_WIDTH-1:0]                 cache_addr,
    output logic [WORDS_PER_BLOCK*DATA_WIDTH-1:0] cache_w_data
);

    refill_state_t           state_q;
    refill_state_t           state_d;
    logic [ADDR_WIDTH-1:0]   miss_addr;
    logic [OFFSET_BITS-1:0]  beat_cnt;
    logic [OFFSET_BITS-1:0]  word_sel;
    logic [ADDR_WIDTH-1:0]   block_base;
    logic                    miss;
    logic                    capture;
    logic                    beat_done;

    assign miss = cpu_rd_en & ~hit;

`ifdef CRITICAL_WORD_FIRST_EN
    assign word_sel = calc_word_sel(miss_addr[OFFSET_BITS-1:0], beat_cnt);
`else
    assign word_sel = beat_cnt;
`endif

    assign block_base = miss_addr & ~ADDR_WIDTH'(WORDS_PER_BLOCK - 1);
    assign mem_addr   = block_base | ADDR_WIDTH'(word_sel);
    assign cache_addr = block_base;

    // State register; reset abandons any in-flight refill.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control outputs; stall is combinational in IDLE so the
    // processor freezes in the same cycle the miss is presented.
    always_comb begin
        state_d     = state_q;
        stall       = 1'b0;
        mem_req     = 1'b0;
        cache_wr_en = 1'b0;
        capture     = 1'b0;
        beat_done   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (miss) begin
                    stall   = 1'b1;
                    capture = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                if (mem_ready) begin
                    beat_done = 1'b1;
                    if (beat_cnt == 2'd3) begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                stall       = 1'b1;
                cache_wr_en = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Latch the miss address and count completed beats of the current refill.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            miss_addr <= '0;
            beat_cnt  <= '0;
        end else if (capture) begin
            miss_addr <= cpu_addr;
            beat_cnt  <= '0;
        end else if (beat_done) begin
            beat_cnt  <= beat_cnt + 2'd1;
        end
    end

    refill_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_refill_buffer (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (beat_done),
        .wr_sel     (word_sel),
        .wr_data    (mem_rdata),
        .block_data (cache_w_data)
    );

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl. Expected memory addresses and
// packed blocks are queued when a miss is launched and popped as the DUT
// completes beats and the block write. Follows CRITICAL_WORD_FIRST_EN if set.
module tb_cache_refill_ctrl;

    logic        clk;
    logic        reset;
    logic        cpu_rd_en;
    logic [31:0] cpu_addr;
    logic        hit;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [7:0]  mem_rdata;
    logic        cache_wr_en;
    logic [31:0] cache_addr;
    logic [31:0] cache_w_data;

    int tests;
    int fails;

    logic [31:0] addr_q [$];
    logic [31:0] blk_q  [$];

    cache_refill_ctrl #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_rd_en    (cpu_rd_en),
        .cpu_addr     (cpu_addr),
        .hit          (hit),
        .stall        (stall),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .cache_wr_en  (cache_wr_en),
        .cache_addr   (cache_addr),
        .cache_w_data (cache_w_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word offset of beat k for a miss whose requested word is at offset off.
    function automatic logic [1:0] beat_offset(input logic [1:0] off, input int k);
        logic [1:0] kk;
        kk = 2'(k);
`ifdef CRITICAL_WORD_FIRST_EN
        return off + kk;
`else
        return kk;
`endif
    endfunction

    // Run one full miss; memory answers every 'period' cycles with base+offset.
    task automatic run_miss(input logic [31:0] addr, input logic [7:0] base,
                            input int period, output int fill_cyc);
        logic [31:0] prev_addr;
        logic        prev_wait;
        logic [31:0] exp_a;
        logic [31:0] exp_blk;
        int          wait_cnt;
        int          beat_cycles;
        int          cyc;
        bit          done;
        for (int k = 0; k < 4; k++) begin
            addr_q.push_back({addr[31:2], beat_offset(addr[1:0], k)});
        end
        blk_q.push_back({base + 8'd3, base + 8'd2, base + 8'd1, base});
        @(negedge clk);
        cpu_rd_en = 1'b1;
        cpu_addr  = addr;
        hit       = 1'b0;
        mem_ready = 1'b0;
        #1;
        tests++;
        if (stall !== 1'b1) begin
            fails++;
            $display("[TB] FAIL miss_stall addr=%h got=%b exp=1", addr, stall);
        end
        cyc = 0; prev_wait = 1'b0; prev_addr = '0; wait_cnt = 0;
        beat_cycles = 0; done = 1'b0; fill_cyc = -1;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            mem_ready = 1'b0;
            if (cyc == 1) begin
                tests++;
                if (mem_req !== 1'b1) begin
                    fails++;
                    $display("[TB] FAIL first_req addr=%h got=%b exp=1", addr, mem_req);
                end
            end
            if (mem_req === 1'b1) begin
                if (prev_wait) begin
                    tests++;
                    if (mem_addr !== prev_addr) begin
                        fails++;
                        $display("[TB] FAIL addr_hold got=%h exp=%h", mem_addr, prev_addr);
                    end
                end
                beat_cycles++;
                if (wait_cnt == period - 1) begin
                    mem_ready = 1'b1;
                    mem_rdata = base + 8'(mem_addr[1:0]);
                    wait_cnt  = 0;
                    prev_wait = 1'b0;
                    tests++;
                    if (addr_q.size() == 0) begin
                        fails++;
                        $display("[TB] FAIL extra_beat got=%h exp=none", mem_addr);
                    end else begin
                        exp_a = addr_q.pop_front();
                        if (mem_addr !== exp_a) begin
                            fails++;
                            $display("[TB] FAIL beat_addr got=%h exp=%h", mem_addr, exp_a);
                        end
                    end
                end else begin
                    wait_cnt++;
                    prev_wait = 1'b1;
                    prev_addr = mem_addr;
                end
            end else begin
                prev_wait = 1'b0;
            end
            if (cache_wr_en === 1'b1) begin
                done     = 1'b1;
                fill_cyc = cyc;
                hit      = 1'b1;
                tests++;
                if (blk_q.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL extra_fill got=%h exp=none", cache_w_data);
                end else begin
                    exp_blk = blk_q.pop_front();
                    if (cache_w_data !== exp_blk) begin
                        fails++;
                        $display("[TB] FAIL fill_data got=%h exp=%h", cache_w_data, exp_blk);
                    end
                end
                tests++;
                if (cache_addr !== {addr[31:2], 2'b00}) begin
                    fails++;
                    $display("[TB] FAIL fill_addr got=%h exp=%h", cache_addr, {addr[31:2], 2'b00});
                end
                tests++;
                if (addr_q.size() != 0) begin
                    fails++;
                    $display("[TB] FAIL beats_missing got=%0d exp=0", addr_q.size());
                end
            end
        end
        if (!done) begin
            tests++;
            fails++;
            $display("[TB] FAIL fill_timeout addr=%h got=no_fill exp=fill", addr);
            addr_q.delete();
            blk_q.delete();
        end
        @(negedge clk);
        cyc++;
        tests++;
        if (stall !== 1'b0 || cache_wr_en !== 1'b0 || mem_req !== 1'b0) begin
            fails++;
            $display("[TB] FAIL post_fill stall=%b wr=%b req=%b exp=0,0,0", stall, cache_wr_en, mem_req);
        end
        tests++;
        if (cyc != 2 + beat_cycles) begin
            fails++;
            $display("[TB] FAIL penalty got=%0d exp=%0d", cyc, 2 + beat_cycles);
        end
        cpu_rd_en = 1'b0;
        hit       = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; cpu_rd_en = 1'b0; cpu_addr = '0; hit = 1'b0;
        mem_ready = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        tests++;
        if ({stall, mem_req, cache_wr_en} !== 3'b000 || mem_addr !== 32'h0 ||
            cache_addr !== 32'h0 || cache_w_data !== 32'h0) begin
            fails++;
            $display("[TB] FAIL reset_outputs st=%b rq=%b wr=%b ma=%h ca=%h cd=%h exp=all zero",
                     stall, mem_req, cache_wr_en, mem_addr, cache_addr, cache_w_data);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_hit_path();
        cpu_rd_en = 1'b1; cpu_addr = 32'h0000_0080; hit = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (stall !== 1'b0 || mem_req !== 1'b0) begin
                fails++;
                $display("[TB] FAIL hit_path stall=%b req=%b exp=0,0", stall, mem_req);
            end
        end
        cpu_rd_en = 1'b0; hit = 1'b0;
    endtask

    task automatic test_zero_wait();
        int fc;
        run_miss(32'h0000_0104, 8'hA0, 1, fc);
        tests++;
        if (fc != 5) begin
            fails++;
            $display("[TB] FAIL zero_wait_fill_cycle got=%0d exp=5", fc);
        end
    endtask

    task automatic test_wait_states();
        int fc;
        run_miss(32'h0000_0121, 8'hB0, 3, fc);
        tests++;
        if (fc != 13) begin
            fails++;
            $display("[TB] FAIL wait_fill_cycle got=%0d exp=13", fc);
        end
    endtask

    task automatic test_critical_word();
        int fc;
        run_miss(32'h0000_0206, 8'hD0, 1, fc);
        tests++;
        if (fc != 5) begin
            fails++;
            $display("[TB] FAIL cwf_fill_cycle got=%0d exp=5", fc);
        end
    endtask

    task automatic test_reset_mid_fetch();
        int fc;
        @(negedge clk);
        cpu_rd_en = 1'b1; cpu_addr = 32'h0000_0300; hit = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            mem_ready = (c <= 2);
            mem_rdata = 8'hE0 + 8'(c);
        end
        tests++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0302) begin
            fails++;
            $display("[TB] FAIL beat2_addr req=%b got=%h exp=1,00000302", mem_req, mem_addr);
        end
        cpu_rd_en = 1'b0;
        reset     = 1'b0;
        #1;
        tests++;
        if (mem_req !== 1'b0 || stall !== 1'b0 || cache_wr_en !== 1'b0 ||
            mem_addr !== 32'h0 || cache_w_data !== 32'h0) begin
            fails++;
            $display("[TB] FAIL reset_mid_fetch rq=%b st=%b wr=%b ma=%h cd=%h exp=0",
                     mem_req, stall, cache_wr_en, mem_addr, cache_w_data);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_miss(32'h0000_0308, 8'hC0, 1, fc);
    endtask

    task automatic test_spurious_ready();
        int fc;
        cpu_rd_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_ready = 1'b1;
            mem_rdata = 8'h55;
            #1;
            tests++;
            if (mem_req !== 1'b0 || stall !== 1'b0 || cache_wr_en !== 1'b0 ||
                cache_w_data !== 32'hC3C2C1C0) begin
                fails++;
                $display("[TB] FAIL spurious_ready rq=%b st=%b wr=%b cd=%h exp=0,0,0,c3c2c1c0",
                         mem_req, stall, cache_wr_en, cache_w_data);
            end
        end
        @(negedge clk);
        mem_ready = 1'b0;
        run_miss(32'h0000_040C, 8'h10, 1, fc);
    endtask

    task automatic test_back_to_back();
        int fc;
        run_miss(32'h0000_0500, 8'h20, 2, fc);
        run_miss(32'h0000_0513, 8'h30, 1, fc);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_hit_path();
        test_zero_wait();
        test_wait_states();
        test_critical_word();
        test_reset_mid_fetch();
        test_spurious_ready();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
